// File: rtl/subseq_feeder_pkg.sv
// subseq_feeder_pkg: feeder state encoding and the frame defaults it shares with the
// max-subsequence-sum engine.
package subseq_feeder_pkg;
    localparam int DW_DEF = 8;
    localparam int FRAME_LEN_DEF = 8;
    typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head read and an occupancy count.
module sync_fifo import subseq_feeder_pkg::*; #(
    parameter int DW = DW_DEF,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign head = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/subseq_feeder.sv
// subseq_feeder: buffers a sample stream and releases it to the engine only as whole,
// gap-free frames, waiting for the engine's done pulse between frames.
module subseq_feeder import subseq_feeder_pkg::*; #(
    parameter int DW = DW_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          frame_valid,
    output logic [DW-1:0] frame_data,
    input  logic          done_in,
    output logic          busy,
    output logic [15:0]   frames_sent,
    output logic          err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int FW = $clog2(FRAME_LEN) + 1;
    state_t state, state_nx;
    logic full, empty, pop, done_q, done_rise, timed_out;
    logic [CW-1:0] count;
    logic [DW-1:0] head;
    logic [FW-1:0] fcnt;
    logic [TW-1:0] tcnt;
    sync_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(s_valid),
        .pop(pop),
        .din(s_data),
        .head(head),
        .full(full),
        .empty(empty),
        .count(count)
    );
    assign s_ready = !full;
    assign busy = state != IDLE;
    assign done_rise = done_in && !done_q;
    assign timed_out = tcnt == TW'(TIMEOUT - 1);
    // The first pop happens on the IDLE->SEND decision so frame_valid rises one cycle later.
    always_comb begin
        state_nx = state;
        pop = 1'b0;
        unique case (state)
            IDLE: if (count >= CW'(FRAME_LEN)) begin
                state_nx = SEND;
                pop = 1'b1;
            end
            SEND: begin
                pop = !empty;
                if (fcnt == FW'(FRAME_LEN - 1)) state_nx = WAIT;
            end
            WAIT: if (done_rise || timed_out) state_nx = GAP;
            GAP:  state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            frame_valid <= 1'b0;
            frame_data <= '0;
            done_q <= 1'b0;
            fcnt <= '0;
            tcnt <= '0;
            frames_sent <= '0;
            err <= 1'b0;
        end else begin
            state <= state_nx;
            frame_valid <= pop;
            if (pop) frame_data <= head;
            done_q <= done_in;
            fcnt <= pop ? fcnt + FW'(1) : '0;
            tcnt <= (state == WAIT) ? tcnt + TW'(1) : '0;
            frames_sent <= frames_sent + 16'(state == WAIT && done_rise);
            err <= err | (state == WAIT && !done_rise && timed_out);
        end
endmodule

// File: tb/tb_subseq_feeder.sv
// tb_subseq_feeder: directed scenarios plus randomized traffic against a queue-based
// model of the sample stream and a small engine model that answers each frame.
module tb_subseq_feeder;
    localparam int FL = 8;
    localparam int DEPTH = 16;
    localparam int TO = 64;
    logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0;
    logic s_ready, frame_valid, done_in, busy, err;
    logic [7:0] s_data = '0;
    logic signed [7:0] frame_data;
    logic [15:0] frames_sent;
    logic done_hold = 1'b0, done_pulse = 1'b0, eng_on = 1'b0;
    int checks = 0, errors = 0, pulses = 0, run = 0, dly = 0, pushed = 0;
    int n, bad, p0;
    int exp_q[$];
    int pat[8] = '{3, -2, 5, -1, -7, 4, 4, -9};

    assign done_in = done_hold | done_pulse;

    subseq_feeder dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .frame_valid(frame_valid),
        .frame_data(frame_data),
        .done_in(done_in),
        .busy(busy),
        .frames_sent(frames_sent),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        logic acc;
        s_valid = 1'b1;
        s_data = v[7:0];
        acc = s_ready;
        tick();
        s_valid = 1'b0;
        if (acc) begin
            exp_q.push_back(int'($signed(v[7:0])));
            pushed++;
        end
    endtask

    task automatic do_reset();
        #1;
        rst = 1'b0;
        s_valid = 1'b0;
        done_hold = 1'b0;
        eng_on = 1'b0;
        #1;
        check("rst_frame_valid", int'(frame_valid), 0);
        check("rst_frame_data", int'(frame_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frames_sent", int'(frames_sent), 0);
        check("rst_err", int'(err), 0);
        check("rst_s_ready", int'(s_ready), 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    // Stream monitor: every frame sample must be the oldest accepted sample, bursts are
    // exactly FL long, and the engine model answers each burst with one done pulse.
    always @(posedge clk) begin
        #1;
        done_pulse = 1'b0;
        if (!rst) begin
            run = 0;
            dly = 0;
        end else if (frame_valid) begin
            if (exp_q.size() != 0) check("frame_data", int'(frame_data), exp_q.pop_front());
            else check("frame_data_extra", int'(frame_data), 999);
            run++;
        end else if (run != 0) begin
            check("burst_len", run, FL);
            run = 0;
            if (eng_on) dly = int'($urandom_range(1, 20));
        end else if (dly != 0) begin
            dly--;
            if (dly == 0) begin
                done_pulse = 1'b1;
                pulses++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // no engine answer: one clean burst, then a timeout
        foreach (pat[i]) push(pat[i]);
        check("s1_lat_before", int'(frame_valid), 0);
        tick();
        check("s1_lat_first", int'(frame_valid), 1);
        n = 0;
        while (frame_valid && n < 20) begin tick(); n++; end
        check("s1_len", n, FL);
        n = 1;
        while (!err && n < 200) begin tick(); n++; end
        check("s1_timeout_cycles", n, TO);
        check("s1_frames_sent", int'(frames_sent), 0);
        tick();
        check("s1_idle_after_gap", int'(busy), 0);
        check("s1_err_sticky", int'(err), 1);

        do_reset();
        // engine answers 11 cycles after the last sample
        foreach (pat[i]) push(pat[i]);
        repeat (11) tick();
        done_hold = 1'b1;
        tick();
        check("s2_frames_sent", int'(frames_sent), 1);
        check("s2_gap_busy", int'(busy), 1);
        check("s2_gap_fv", int'(frame_valid), 0);
        done_hold = 1'b0;
        tick();
        check("s2_idle", int'(busy), 0);
        check("s2_err", int'(err), 0);

        do_reset();
        // seven samples must not start a frame
        for (int i = 0; i < 7; i++) push(pat[i]);
        bad = 0;
        repeat (30) begin tick(); bad += int'(frame_valid | busy); end
        check("s3_hold_off", bad, 0);
        push(pat[7]);
        check("s3_lat_before", int'(frame_valid), 0);
        tick();
        check("s3_lat_first", int'(frame_valid), 1);
        repeat (12) tick();

        do_reset();
        // reset in the fourth SEND cycle
        foreach (pat[i]) push(pat[i]);
        repeat (4) tick();
        check("s4_in_send", int'(frame_valid), 1);
        do_reset();
        for (int i = 0; i < 4; i++) push(int'($urandom_range(0, 255)));
        bad = 0;
        repeat (20) begin tick(); bad += int'(frame_valid | busy); end
        check("s4_fifo_cleared", bad, 0);
        for (int i = 0; i < 4; i++) push(int'($urandom_range(0, 255)));
        repeat (12) tick();

        do_reset();
        // done already high on WAIT entry does not count; a fresh rise does, once
        done_hold = 1'b1;
        foreach (pat[i]) push(pat[i]);
        repeat (25) tick();
        check("s5_no_level_count", int'(frames_sent), 0);
        done_hold = 1'b0;
        tick();
        done_hold = 1'b1;
        tick();
        check("s5_rise_count", int'(frames_sent), 1);
        repeat (3) tick();
        check("s5_single_count", int'(frames_sent), 1);
        check("s5_idle", int'(busy), 0);
        done_hold = 1'b0;

        do_reset();
        // always-valid source, no answer: FIFO fills to FIFO_DEPTH after the first frame
        pushed = 0;
        for (int i = 0; i < 40; i++) push(int'($urandom_range(0, 255)));
        check("s6_accepted", pushed, DEPTH + FL);
        check("s6_s_ready_full", int'(s_ready), 0);
        eng_on = 1'b1;
        done_hold = 1'b1;
        tick();
        done_hold = 1'b0;
        n = 0;
        while ((frames_sent != 16'd3 || busy) && n < 600) begin tick(); n++; end
        check("s6_frames_sent", int'(frames_sent), 3);
        check("s6_all_delivered", exp_q.size(), 0);
        check("s6_err", int'(err), 0);
        check("s6_s_ready", int'(s_ready), 1);

        do_reset();
        // randomized traffic with a randomly slow engine
        eng_on = 1'b1;
        p0 = pulses;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) != 0) push(int'($urandom_range(0, 255)));
            else tick();
        end
        repeat (150) tick();
        check("s7_frames_sent", int'(frames_sent), pulses - p0);
        check("s7_err", int'(err), 0);
        check("s7_residue_below_frame", int'(exp_q.size() < FL), 1);
        check("s7_idle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
